// File: rtl/exec_unit_pipe.sv
// ALU execution stage: one-cycle add/sub, iterative shift-add multiply,
// result held in a valid/ready output stage until the writeback side takes it.
module exec_unit_pipe #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned SIZE     = 64,
   parameter int unsigned SATURATE = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              opcode,
   input  logic [WIDTH-1:0]        src1,
   input  logic [WIDTH-1:0]        src2,
   input  logic [$clog2(SIZE)-1:0] dst_addr,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        dst,
   output logic [$clog2(SIZE)-1:0] dst_out,
   output logic                    ovf,
   output logic                    zero,
   output logic                    busy
);

   localparam int unsigned TAG_W = $clog2(SIZE);
   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned PW    = 2 * WIDTH;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} state_t;

   state_t            state, state_d, start_state;
   logic [PW-1:0]     acc, a_sh, mul_next;
   logic [WIDTH-1:0]  b_sh;
   logic [CNT_W-1:0]  cnt;
   logic [TAG_W-1:0]  tag_q;
   logic [WIDTH:0]    sum_c;
   logic [WIDTH-1:0]  raw_c, sat_c, res_c;
   logic              of_c, accept, mul_last, load_res;

   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign mul_last  = (state == MUL_RUN) && (cnt == CNT_W'(WIDTH - 1));
   assign load_res  = mul_last || (accept && ((opcode == OP_ADD) || (opcode == OP_SUB)));
   assign sum_c     = {1'b0, src1} + {1'b0, src2};
   assign mul_next  = acc + (b_sh[0] ? a_sh : PW'(0));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Next state; a consume in DONE may chain straight into the next command
   always_comb begin
      state_d     = state;
      start_state = IDLE;
      case (opcode)
         OP_MUL:         start_state = MUL_RUN;
         OP_ADD, OP_SUB: start_state = DONE;
         OP_NOP:         start_state = IDLE;
         default:        start_state = IDLE;
      endcase
      case (state)
         IDLE:    if (accept) state_d = start_state;
         MUL_RUN: if (mul_last) state_d = DONE;
         DONE:    if (out_ready) state_d = accept ? start_state : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Result selection: multiplier completion or the incoming add/sub
   always_comb begin
      raw_c = '0;
      of_c  = 1'b0;
      sat_c = '0;
      if (state == MUL_RUN) begin
         raw_c = mul_next[WIDTH-1:0];
         of_c  = |mul_next[PW-1:WIDTH];
         sat_c = '1;
      end else if (opcode == OP_SUB) begin
         raw_c = src1 - src2;
         of_c  = (src1 < src2);
         sat_c = '0;
      end else begin
         raw_c = sum_c[WIDTH-1:0];
         of_c  = sum_c[WIDTH];
         sat_c = '1;
      end
      res_c = ((SATURATE != 0) && of_c) ? sat_c : raw_c;
   end

   // Multiplier engine and output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         a_sh    <= '0;
         b_sh    <= '0;
         cnt     <= '0;
         tag_q   <= '0;
         dst     <= '0;
         dst_out <= '0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
      end else begin
         if (accept) begin
            acc   <= '0;
            a_sh  <= PW'(src1);
            b_sh  <= src2;
            cnt   <= '0;
            tag_q <= dst_addr;
         end else if (state == MUL_RUN) begin
            acc  <= mul_next;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + CNT_W'(1);
         end
         if (load_res) begin
            dst     <= res_c;
            ovf     <= of_c;
            zero    <= (res_c == '0);
            dst_out <= mul_last ? tag_q : dst_addr;
         end
      end
   end

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Bench for exec_unit_pipe: wrap and saturating instances driven in lockstep,
// checked against an arithmetic reference model.
module tb_exec_unit_pipe;

   localparam int unsigned W  = 8;
   localparam int unsigned TW = 6;
   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, out_ready;
   logic [1:0]    opcode;
   logic [W-1:0]  src1, src2;
   logic [TW-1:0] dst_addr;

   logic          ir0, ov0, f0, z0, b0, ir1, ov1, f1, z1, b1;
   logic [W-1:0]  d0, d1;
   logic [TW-1:0] t0, t1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   exec_unit_pipe #(.WIDTH(W), .SIZE(64), .SATURATE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .opcode(opcode),
      .src1(src1), .src2(src2), .dst_addr(dst_addr), .out_valid(ov0), .out_ready(out_ready),
      .dst(d0), .dst_out(t0), .ovf(f0), .zero(z0), .busy(b0));

   exec_unit_pipe #(.WIDTH(W), .SIZE(64), .SATURATE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .opcode(opcode),
      .src1(src1), .src2(src2), .dst_addr(dst_addr), .out_valid(ov1), .out_ready(out_ready),
      .dst(d1), .dst_out(t1), .ovf(f1), .zero(z1), .busy(b1));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the unsigned operands
   function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit sat, output longint d, output bit o);
      longint modv = longint'(1) << W;
      longint full;
      d = 0;
      o = 1'b0;
      case (op)
         OP_ADD: begin
            full = longint'(a) + longint'(b);
            o = full >= modv;
            d = (o && sat) ? modv - 1 : full % modv;
         end
         OP_SUB: begin
            o = a < b;
            d = (o && sat) ? 0 : (longint'(a) - longint'(b) + modv) % modv;
         end
         OP_MUL: begin
            full = longint'(a) * longint'(b);
            o = full >= modv;
            d = (o && sat) ? modv - 1 : full % modv;
         end
         default: ;
      endcase
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 64'(ir0), 64'd1);
      chk({tag, "_out_valid"}, 64'(ov0), 64'd0);
      chk({tag, "_dst"}, 64'(d0), 64'd0);
      chk({tag, "_dst_out"}, 64'(t0), 64'd0);
      chk({tag, "_ovf"}, 64'(f0), 64'd0);
      chk({tag, "_zero"}, 64'(z0), 64'd0);
      chk({tag, "_busy"}, 64'(b0), 64'd0);
      chk({tag, "_sat_out_valid"}, 64'(ov1), 64'd0);
      chk({tag, "_sat_dst"}, 64'(d1), 64'd0);
      chk({tag, "_sat_busy"}, 64'(b1), 64'd0);
   endtask

   // Wait (bounded) for in_ready, then present one command for one edge
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag);
      int n = 0;
      @(negedge clk);
      while (!ir0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("issue_in_ready", 64'(ir0), 64'd1);
      in_valid = 1'b1;
      opcode   = op;
      src1     = a;
      src2     = b;
      dst_addr = tag;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      opcode   = 2'($urandom);
      src1     = W'($urandom);
      src2     = W'($urandom);
      dst_addr = TW'($urandom);
   endtask

   task automatic expect_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [TW-1:0] tag, input int hold);
      longint e0, e1;
      bit     o0, o1;
      int     lat = 0;
      if (op == OP_NOP) begin
         @(negedge clk);
         chk("nop_out_valid", 64'(ov0), 64'd0);
         chk("nop_in_ready", 64'(ir0), 64'd1);
         return;
      end
      model(op, a, b, 1'b0, e0, o0);
      model(op, a, b, 1'b1, e1, o1);
      do begin
         @(negedge clk);
         lat++;
      end while (!ov0 && lat < 40);
      chk("latency", 64'(lat), (op == OP_MUL) ? 64'(W + 1) : 64'd1);
      chk("sat_out_valid", 64'(ov1), 64'd1);
      chk("dst", 64'(d0), 64'(e0));
      chk("sat_dst", 64'(d1), 64'(e1));
      chk("ovf", 64'(f0), 64'(o0));
      chk("sat_ovf", 64'(f1), 64'(o1));
      chk("zero", 64'(z0), 64'(e0 == 0));
      chk("sat_zero", 64'(z1), 64'(e1 == 0));
      chk("dst_out", 64'(t0), 64'(tag));
      chk("sat_dst_out", 64'(t1), 64'(tag));
      chk("busy_done", 64'(b0), 64'd1);
      chk("in_ready_held", 64'(ir0), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(ov0), 64'd1);
         chk("hold_dst", 64'(d0), 64'(e0));
         chk("hold_sat_dst", 64'(d1), 64'(e1));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("consumed", 64'(ov0), 64'd0);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, input int hold);
      issue(op, a, b, tag);
      expect_result(op, a, b, tag, hold);
   endtask

   initial begin
      logic [1:0]    rop;
      logic [W-1:0]  ra, rb;
      logic [TW-1:0] rt;
      int            stray;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      opcode    = OP_NOP;
      src1      = '0;
      src2      = '0;
      dst_addr  = '0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;

      // Directed arithmetic and boundary cases
      run_cmd(OP_ADD, 8'd100, 8'd27, 6'd5, 0);
      run_cmd(OP_ADD, 8'd200, 8'd100, 6'd1, 1);
      run_cmd(OP_SUB, 8'd3, 8'd5, 6'd2, 0);
      run_cmd(OP_SUB, 8'd9, 8'd9, 6'd8, 0);
      run_cmd(OP_MUL, 8'd12, 8'd11, 6'd63, 0);
      run_cmd(OP_MUL, 8'd16, 8'd16, 6'd4, 0);
      run_cmd(OP_MUL, 8'd0, 8'd200, 6'd6, 0);
      run_cmd(OP_MUL, 8'd255, 8'd255, 6'd7, 0);
      run_cmd(OP_ADD, 8'd255, 8'd1, 6'd10, 0);

      // Back-pressure, then same-edge consume and accept
      issue(OP_ADD, 8'd50, 8'd60, 6'd9);
      @(negedge clk);
      chk("bp_valid", 64'(ov0), 64'd1);
      in_valid = 1'b1;
      opcode   = OP_ADD;
      src1     = 8'd1;
      src2     = 8'd1;
      dst_addr = 6'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 64'(ov0), 64'd1);
         chk("bp_hold_dst", 64'(d0), 64'd110);
         chk("bp_hold_tag", 64'(t0), 64'd9);
         chk("bp_in_ready", 64'(ir0), 64'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(ir0), 64'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
      chk("b2b_valid", 64'(ov0), 64'd1);
      chk("b2b_dst", 64'(d0), 64'd2);
      chk("b2b_tag", 64'(t0), 64'd3);
      expect_result(OP_ADD, 8'd1, 8'd1, 6'd3, 0);

      // NOP stream
      @(negedge clk);
      in_valid = 1'b1;
      opcode   = OP_NOP;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("nop_stream_ready", 64'(ir0), 64'd1);
         chk("nop_stream_valid", 64'(ov0), 64'd0);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("nop_stream_after", 64'(ov0), 64'd0);
      chk("nop_stream_busy", 64'(b0), 64'd0);

      // Asynchronous reset in the middle of a multiply
      issue(OP_MUL, 8'd200, 8'd3, 6'd7);
      repeat (3) @(negedge clk);
      chk("mul_busy", 64'(b0), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ov0 || ov1) stray++;
      end
      chk("abandoned_mul_no_output", 64'(stray), 64'd0);
      run_cmd(OP_ADD, 8'd7, 8'd8, 6'd12, 0);

      // Randomized commands with random consumer delay
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom);
         ra  = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
         rb  = ($urandom_range(0, 7) == 0) ? 8'd255 : W'($urandom);
         rt  = TW'($urandom);
         run_cmd(rop, ra, rb, rt, int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
